// File: rtl/puls_debounce.sv
// puls_debounce: two-flop synchronizer plus per-channel stability counter for push-button pins.
// Define PULS_DEBOUNCE_EDGE_EN to get one-cycle press/release strobes; otherwise they are tied to 0.
module puls_debounce #(
    parameter int N               = 2,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] puls_raw,
    output logic [N-1:0] puls_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [N-1:0] ff1, ff2, acc;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ff1 <= '0;
            ff2 <= '0;
        end else begin
            ff1 <= puls_raw;
            ff2 <= ff1;
        end
    for (genvar i = 0; i < N; i++) begin : g_ch
        logic             st;
        logic [CNT_W-1:0] cnt;
        assign acc[i]    = (ff2[i] != st) && (cnt == LAST);
        assign puls_o[i] = st;
        // the counter clears both when the sample falls back and on acceptance, so it never wraps
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                st  <= 1'b0;
                cnt <= '0;
            end else begin
                st  <= acc[i] ? ff2[i] : st;
                cnt <= (ff2[i] == st || acc[i]) ? '0 : cnt + 1'b1;
            end
    end
`ifdef PULS_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            press_o   <= '0;
            release_o <= '0;
        end else begin
            press_o   <= acc & ff2;
            release_o <= acc & ~ff2;
        end
`else
    assign press_o   = '0;
    assign release_o = '0;
`endif
endmodule

// File: tb/tb_puls_debounce.sv
// tb_puls_debounce: randomized and directed checks of puls_debounce against a window-based reference model.
module tb_puls_debounce;
    localparam int N = 2;
    localparam int D = 4;
`ifdef PULS_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] puls_raw = '0;
    logic [N-1:0] puls_o, press_o, release_o;
    int n_checks = 0;
    int n_pass = 0;

    puls_debounce #(.N(N), .CNT_W(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .puls_raw(puls_raw),
        .puls_o(puls_o), .press_o(press_o), .release_o(release_o)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the last D synchronized samples all differ from the stable level.
    logic [N-1:0] pipe[$];
    logic [N-1:0] sq[$];
    logic [N-1:0] m_st, m_press, m_rel;

    function automatic void model_reset();
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
        sq.delete();
        m_st = '0;
        m_press = '0;
        m_rel = '0;
    endfunction

    function automatic void model_edge(input logic [N-1:0] raw);
        logic [N-1:0] s, acc;
        bit all;
        s = pipe.pop_front();
        pipe.push_back(raw);
        sq.push_back(s);
        if (sq.size() > D) void'(sq.pop_front());
        acc = '0;
        for (int c = 0; c < N; c++) begin
            all = (sq.size() == D);
            foreach (sq[j]) if (sq[j][c] == m_st[c]) all = 0;
            acc[c] = all;
        end
        m_press = EDGE ? (acc & s) : '0;
        m_rel = EDGE ? (acc & ~s) : '0;
        m_st = m_st ^ acc;
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset) model_edge(puls_raw);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        puls_raw = 2'b11;
        model_reset();
        for (int e = 0; e < 3; e++) begin
            step();
            n_checks++;
            if ({puls_o, press_o, release_o} !== 6'b0)
                $display("FAIL reset_hold: got %b/%b/%b expected 00/00/00", puls_o, press_o, release_o);
            else n_pass++;
        end
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (puls_o !== (e >= 6 ? 2'b11 : 2'b00) || press_o !== ((EDGE && e == 6) ? 2'b11 : 2'b00))
                $display("FAIL reset_release e%0d: got puls=%b press=%b", e, puls_o, press_o);
            else n_pass++;
            n_checks++;
            if ({puls_o, press_o, release_o} !== {m_st, m_press, m_rel})
                $display("FAIL reset_model e%0d: got %b/%b/%b expected %b/%b/%b", e, puls_o, press_o, release_o, m_st, m_press, m_rel);
            else n_pass++;
        end
        puls_raw = 2'b00;
        for (int e = 0; e < 10; e++) begin
            step();
            n_checks++;
            if ({puls_o, press_o, release_o} !== {m_st, m_press, m_rel})
                $display("FAIL reset_drop e%0d: got %b/%b/%b expected %b/%b/%b", e, puls_o, press_o, release_o, m_st, m_press, m_rel);
            else n_pass++;
        end
    endtask

    task automatic test_press();
        puls_raw[0] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            n_checks++;
            if (puls_o !== {1'b0, e >= 5} || press_o !== {1'b0, EDGE && e == 5} || release_o !== 2'b00)
                $display("FAIL press e%0d: got puls=%b press=%b rel=%b", e, puls_o, press_o, release_o);
            else n_pass++;
            n_checks++;
            if ({puls_o, press_o, release_o} !== {m_st, m_press, m_rel})
                $display("FAIL press_model e%0d: got %b/%b/%b expected %b/%b/%b", e, puls_o, press_o, release_o, m_st, m_press, m_rel);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        int lvl[4] = '{1, 0, 1, 0};
        int len[4] = '{3, 2, 3, 6};
        for (int k = 0; k < 4; k++) begin
            puls_raw[1] = lvl[k][0];
            for (int e = 0; e < len[k]; e++) begin
                step();
                n_checks++;
                if ({puls_o[1], press_o[1], release_o[1]} !== 3'b000 || puls_o[0] !== 1'b1)
                    $display("FAIL bounce k%0d e%0d: got puls=%b press=%b rel=%b", k, e, puls_o, press_o, release_o);
                else n_pass++;
            end
        end
        puls_raw[1] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            n_checks++;
            if ({puls_o, press_o, release_o} !== {m_st, m_press, m_rel})
                $display("FAIL bounce_hold e%0d: got %b/%b/%b expected %b/%b/%b", e, puls_o, press_o, release_o, m_st, m_press, m_rel);
            else n_pass++;
        end
        n_checks++;
        if (puls_o !== 2'b11) $display("FAIL bounce_accept: got %b expected 11", puls_o);
        else n_pass++;
    endtask

    task automatic test_release();
        puls_raw[0] = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            n_checks++;
            if (puls_o !== {1'b1, e < 5} || release_o !== {1'b0, EDGE && e == 5} || press_o !== 2'b00)
                $display("FAIL release e%0d: got puls=%b press=%b rel=%b", e, puls_o, press_o, release_o);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        puls_raw = 2'b11;
        for (int e = 0; e < 4; e++) step();
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({puls_o, press_o, release_o} !== 6'b0)
            $display("FAIL async_reset: got %b/%b/%b expected 00/00/00", puls_o, press_o, release_o);
        else n_pass++;
        step();
        step();
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (puls_o !== (e >= 6 ? 2'b11 : 2'b00) || press_o !== ((EDGE && e == 6) ? 2'b11 : 2'b00) || release_o !== 2'b00)
                $display("FAIL async_restart e%0d: got puls=%b press=%b rel=%b", e, puls_o, press_o, release_o);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        puls_raw = 2'b00;
        for (int e = 0; e < 8; e++) step();
        puls_raw = 2'b11;
        for (int e = 0; e < 7; e++) begin
            step();
            n_checks++;
            if (puls_o !== (e >= 5 ? 2'b11 : 2'b00) || press_o !== ((EDGE && e == 5) ? 2'b11 : 2'b00))
                $display("FAIL simultaneous e%0d: got puls=%b press=%b", e, puls_o, press_o);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int e = 0; e < 400; e++) begin
            if (hold == 0) begin
                puls_raw = N'($urandom_range(0, 3));
                hold = $urandom_range(1, 7);
            end
            hold--;
            step();
            n_checks++;
            if ({puls_o, press_o, release_o} !== {m_st, m_press, m_rel})
                $display("FAIL random e%0d: got %b/%b/%b expected %b/%b/%b", e, puls_o, press_o, release_o, m_st, m_press, m_rel);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_async_reset();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
